// File: rtl/stage_execute_muldiv.sv
// stage_execute_muldiv
//   Iterative multiply/divide unit that owns the architectural HI/LO registers.
//   It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds HI/LO for MFHI/MFLO.
//   While a multiply or divide is in flight, busy=1 so the pipeline can stall
//   dependent instructions.
//
// Ports
//   clk      stage clock, rising edge
//   reset    asynchronous, active-high; clears all state
//   start    issue request for op (taken only when idle and not nullified)
//   nullify  cancels this cycle's issue
//   abort    kills the in-flight operation; HI/LO keep their old values
//   op       0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   rs, rt   operands (dividend/multiplicand, divisor/multiplier)
//   hi, lo   HI/LO registers
//   busy     registered in-flight flag
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no operation in flight; accepts new requests
// S_MUL  | multiply: phase 0 forms the product, phase 1 writes HI/LO
// S_DIV  | one restoring divide step per cycle, WIDTH steps total
// S_FIX  | sign fix-up of quotient/remainder, writes HI/LO

module stage_execute_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             nullify,
  input  logic             abort,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t state, state_next;

  // multiply datapath
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic               mul_signed;
  logic               mul_phase;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext;

  // divide datapath: quo starts as |dividend| and shifts quotient bits in
  logic [WIDTH-1:0]   divisor, quo, rem;
  logic               q_neg, r_neg, div_zero;
  logic [WIDTH-1:0]   orig_rs;
  logic [CNT_W-1:0]   count;
  logic [WIDTH:0]     shifted, trial;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  // issue decode
  logic             issue, is_mul_op, is_div_op;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  always_comb begin
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    issue     = start && !nullify && !abort && (state == S_IDLE);
    rs_neg    = (op == OP_DIV) && rs[WIDTH-1];
    rt_neg    = (op == OP_DIV) && rt[WIDTH-1];
    rs_mag    = rs_neg ? -rs : rs;
    rt_mag    = rt_neg ? -rt : rt;
  end

  // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both
  // MULT and MULTU; the low 2*WIDTH bits are correct in either case.
  always_comb begin
    mul_a_ext = {{WIDTH{mul_signed & mul_a[WIDTH-1]}}, mul_a};
    mul_b_ext = {{WIDTH{mul_signed & mul_b[WIDTH-1]}}, mul_b};
  end

  always_comb begin
    shifted   = {rem, quo[WIDTH-1]};
    trial     = shifted - {1'b0, divisor};
    quo_fixed = q_neg ? -quo : quo;
    rem_fixed = r_neg ? -rem : rem;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (issue && is_mul_op)      state_next = S_MUL;
        else if (issue && is_div_op) state_next = S_DIV;
      end
      S_MUL: begin
        if (abort || mul_phase) state_next = S_IDLE;
      end
      S_DIV: begin
        if (abort)                   state_next = S_IDLE;
        else if (count == LAST_STEP) state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi         <= '0;
      lo         <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      mul_phase  <= 1'b0;
      product    <= '0;
      divisor    <= '0;
      quo        <= '0;
      rem        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_zero   <= 1'b0;
      orig_rs    <= '0;
      count      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            if (op == OP_MTHI) hi <= rs;
            if (op == OP_MTLO) lo <= rs;
            if (is_mul_op) begin
              mul_a      <= rs;
              mul_b      <= rt;
              mul_signed <= (op == OP_MULT);
              mul_phase  <= 1'b0;
            end
            if (is_div_op) begin
              quo      <= rs_mag;
              divisor  <= rt_mag;
              rem      <= '0;
              q_neg    <= rs_neg ^ rt_neg;
              r_neg    <= rs_neg;
              div_zero <= (rt == '0);
              orig_rs  <= rs;
              count    <= '0;
            end
          end
        end
        S_MUL: begin
          if (!abort) begin
            if (!mul_phase) begin
              product   <= mul_a_ext * mul_b_ext;
              mul_phase <= 1'b1;
            end else begin
              hi <= product[2*WIDTH-1:WIDTH];
              lo <= product[WIDTH-1:0];
            end
          end
        end
        S_DIV: begin
          if (!abort) begin
            // trial[WIDTH] set means the subtraction borrowed: restore
            if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            count <= count + 1'b1;
          end
        end
        S_FIX: begin
          if (!abort) begin
            if (div_zero) begin
              lo <= '1;
              hi <= orig_rs;
            end else begin
              lo <= quo_fixed;
              hi <= rem_fixed;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_execute_muldiv.sv
// Self-checking bench for stage_execute_muldiv: directed cases followed by
// random operations compared against an arithmetic reference model.

module tb_stage_execute_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, nullify, abort;
  logic [2:0]  op;
  logic [31:0] rs, rt, hi, lo;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  stage_execute_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .nullify(nullify), .abort(abort),
    .op(op), .rs(rs), .rt(rt), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on the architectural result.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    longint             sa, sb, q, r;
    case (o)
      3'd1: begin sp = $signed(a) * $signed(b); m_hi = sp[63:32]; m_lo = sp[31:0]; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd3: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin
          sa = $signed(a); sb = $signed(b);
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      3'd4: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int busy_len(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return 2;
    if (o == 3'd3 || o == 3'd4) return 33;
    return 0;
  endfunction

  // Issue one op, wait for completion, compare busy length and HI/LO.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    op = o; rs = a; rt = b; start = 1'b1;
    tick();
    start = 1'b0; op = 3'd0; rs = $urandom; rt = $urandom;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    model_op(o, a, b);
    check({tag, " busy_cycles"}, 64'(n), 64'(busy_len(o)));
    check({tag, " hi"}, {32'd0, hi}, {32'd0, m_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    int n;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; nullify = 1'b0; abort = 1'b0;
    op = 3'd0; rs = '0; rt = '0;
    #12;
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    tick();

    run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");
    check("mult_neg hi const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    check("mult_neg lo const", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu hi const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    check("multu lo const", {32'd0, lo}, 64'h0000_0000_0000_0001);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    check("div lo const", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    check("div hi const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    run_op(3'd4, 32'd100, 32'd0, "divu_by_zero");
    run_op(3'd3, 32'd100, 32'd0, "div_by_zero");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    check("ovf lo const", {32'd0, lo}, 64'h0000_0000_8000_0000);
    run_op(3'd5, 32'hCAFE_0001, 32'd0, "mthi");
    run_op(3'd6, 32'hBEEF_0002, 32'd0, "mtlo");

    // Request during busy is dropped.
    op = 3'd4; rs = 32'd100; rt = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = 3'd0;
    repeat (9) tick();
    op = 3'd6; rs = 32'd5; start = 1'b1;
    tick();
    start = 1'b0; op = 3'd0;
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    check("ignored busy_left", 64'(n), 64'd23);
    check("ignored lo", {32'd0, lo}, 64'd14);
    check("ignored hi", {32'd0, hi}, 64'd2);
    model_op(3'd4, 32'd100, 32'd7);

    // Nullified requests.
    nullify = 1'b1; op = 3'd5; rs = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    op = 3'd1;
    tick();
    start = 1'b0; nullify = 1'b0; op = 3'd0;
    check("nullify busy", {63'd0, busy}, 64'd0);
    check("nullify hi", {32'd0, hi}, {32'd0, m_hi});
    check("nullify lo", {32'd0, lo}, {32'd0, m_lo});

    // Abort a divide at cycle 20.
    run_op(3'd5, 32'h11, 32'd0, "pre_hi");
    run_op(3'd6, 32'h22, 32'd0, "pre_lo");
    op = 3'd3; rs = 32'd12345; rt = 32'd17; start = 1'b1;
    tick();
    start = 1'b0; op = 3'd0;
    repeat (19) tick();
    check("abort busy before", {63'd0, busy}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", {63'd0, busy}, 64'd0);
    repeat (15) tick();
    check("abort hi", {32'd0, hi}, 64'h11);
    check("abort lo", {32'd0, lo}, 64'h22);

    // Abort a multiply.
    op = 3'd2; rs = 32'd9; rt = 32'd9; start = 1'b1;
    tick();
    start = 1'b0; op = 3'd0; abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("abort mul busy", {63'd0, busy}, 64'd0);
    check("abort mul lo", {32'd0, lo}, 64'h22);

    // Asynchronous reset in the middle of a divide.
    op = 3'd3; rs = 32'd999; rt = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; op = 3'd0;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    check("areset hi", {32'd0, hi}, 64'd0);
    check("areset lo", {32'd0, lo}, 64'd0);
    check("areset busy", {63'd0, busy}, 64'd0);
    #2 reset = 1'b0;
    m_hi = '0; m_lo = '0;
    tick();
    run_op(3'd4, 32'd1000, 32'd33, "after_reset");

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
